// File: rtl/rv32_mem_arbiter.sv
// Two-master (instruction/data) arbiter onto one Avalon-style memory slave port.
// Optional slave-stall abort is enabled by defining RV_MEM_ARB_TIMEOUT_EN.
module rv32_mem_arbiter #(
  parameter int unsigned ARB_MODE       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ABORT_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [31:0] iaddress,
  input  logic        iread,
  output logic [31:0] ireaddata,
  output logic        iwaitrequest,
  input  logic [31:0] daddress,
  input  logic        dwrite,
  input  logic [31:0] dwritedata,
  input  logic [3:0]  dbyteenable,
  input  logic        dread,
  output logic [31:0] dreaddata,
  output logic        dwaitrequest,
  output logic [31:0] saddress,
  output logic        swrite,
  output logic [31:0] swritedata,
  output logic [3:0]  sbyteenable,
  output logic        sread,
  input  logic [31:0] sreaddata,
  input  logic        swaitrequest,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 1 = data master granted last
  logic   req_i, req_d;
  logic   abort;

  assign req_i = iread;
  assign req_d = dread | dwrite;

`ifdef RV_MEM_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  assign abort = (state_q != IDLE) && (stall_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE) begin
      stall_cnt_d = 16'd0;
    end else if (swaitrequest) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign abort              = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Slave command and master responses are pure muxes of the current grant.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    saddress     = 32'd0;
    swrite       = 1'b0;
    swritedata   = 32'd0;
    sbyteenable  = 4'h0;
    sread        = 1'b0;
    iwaitrequest = 1'b1;
    dwaitrequest = 1'b1;
    ireaddata    = 32'd0;
    dreaddata    = 32'd0;
    timeout      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_d && ((ARB_MODE == 1) || !req_i || !last_grant_q)) begin
          state_d      = GNT_D;
          last_grant_d = 1'b1;
        end else if (req_i) begin
          state_d      = GNT_I;
          last_grant_d = 1'b0;
        end
      end

      GNT_I: begin
        if (abort) begin
          iwaitrequest = 1'b0;
          ireaddata    = ABORT_DATA;
          timeout      = 1'b1;
          state_d      = IDLE;
        end else begin
          saddress     = iaddress;
          sread        = iread;
          sbyteenable  = 4'hf;
          iwaitrequest = swaitrequest;
          ireaddata    = sreaddata;
          if (!iread || !swaitrequest) begin
            state_d = IDLE;
          end
        end
      end

      GNT_D: begin
        if (abort) begin
          dwaitrequest = 1'b0;
          dreaddata    = ABORT_DATA;
          timeout      = 1'b1;
          state_d      = IDLE;
        end else begin
          // A simultaneous read is held off; it is picked up on a later grant.
          saddress     = daddress;
          swrite       = dwrite;
          sread        = dread & ~dwrite;
          swritedata   = dwritedata;
          sbyteenable  = dbyteenable;
          dwaitrequest = swaitrequest;
          dreaddata    = sreaddata;
          if (!req_d || !swaitrequest) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Directed bench for rv32_mem_arbiter: per-cycle vector table plus
// hand-written round-robin / fixed-priority and stall-abort sequences.
module tb_rv32_mem_arbiter;

  logic        clk;
  logic        nreset;
  logic [31:0] iaddress;
  logic        iread;
  logic [31:0] daddress;
  logic        dwrite;
  logic [31:0] dwritedata;
  logic [3:0]  dbyteenable;
  logic        dread;
  logic [31:0] sreaddata;
  logic        swaitrequest;

  logic [31:0] ireaddata, dreaddata, saddress, swritedata;
  logic        iwaitrequest, dwaitrequest, swrite, sread, timeout;
  logic [3:0]  sbyteenable;

  logic [31:0] fp_ireaddata, fp_dreaddata, fp_saddress, fp_swritedata;
  logic        fp_iwaitrequest, fp_dwaitrequest, fp_swrite, fp_sread, fp_timeout;
  logic [3:0]  fp_sbyteenable;

  int total;
  int bad;

  typedef struct {
    logic        rstn;
    logic        iread;
    logic        dread;
    logic        dwrite;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        swait;
    logic [31:0] srdata;
  } stim_t;

  typedef struct {
    logic        sread;
    logic        swrite;
    logic [31:0] saddr;
    logic [31:0] swdata;
    logic [3:0]  sbe;
    logic        iwait;
    logic        dwait;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];

  rv32_mem_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8), .ABORT_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .nreset(nreset),
    .iaddress(iaddress), .iread(iread), .ireaddata(ireaddata), .iwaitrequest(iwaitrequest),
    .daddress(daddress), .dwrite(dwrite), .dwritedata(dwritedata), .dbyteenable(dbyteenable),
    .dread(dread), .dreaddata(dreaddata), .dwaitrequest(dwaitrequest),
    .saddress(saddress), .swrite(swrite), .swritedata(swritedata), .sbyteenable(sbyteenable),
    .sread(sread), .sreaddata(sreaddata), .swaitrequest(swaitrequest), .timeout(timeout)
  );

  rv32_mem_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(8), .ABORT_DATA(32'hDEADBEEF)) dut_fp (
    .clk(clk), .nreset(nreset),
    .iaddress(iaddress), .iread(iread), .ireaddata(fp_ireaddata), .iwaitrequest(fp_iwaitrequest),
    .daddress(daddress), .dwrite(dwrite), .dwritedata(dwritedata), .dbyteenable(dbyteenable),
    .dread(dread), .dreaddata(fp_dreaddata), .dwaitrequest(fp_dwaitrequest),
    .saddress(fp_saddress), .swrite(fp_swrite), .swritedata(fp_swritedata),
    .sbyteenable(fp_sbyteenable), .sread(fp_sread), .sreaddata(sreaddata),
    .swaitrequest(swaitrequest), .timeout(fp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    nreset       = s.rstn;
    iread        = s.iread;
    dread        = s.dread;
    dwrite       = s.dwrite;
    iaddress     = s.iaddr;
    daddress     = s.daddr;
    dwritedata   = s.wdata;
    dbyteenable  = s.be;
    swaitrequest = s.swait;
    sreaddata    = s.srdata;
  endtask

  task automatic checkVector(input int idx, input exp_t e);
    checkOutput("sread", idx, {31'd0, sread}, {31'd0, e.sread});
    checkOutput("swrite", idx, {31'd0, swrite}, {31'd0, e.swrite});
    checkOutput("saddress", idx, saddress, e.saddr);
    checkOutput("swritedata", idx, swritedata, e.swdata);
    checkOutput("sbyteenable", idx, {28'd0, sbyteenable}, {28'd0, e.sbe});
    checkOutput("iwaitrequest", idx, {31'd0, iwaitrequest}, {31'd0, e.iwait});
    checkOutput("dwaitrequest", idx, {31'd0, dwaitrequest}, {31'd0, e.dwait});
    checkOutput("ireaddata", idx, ireaddata, e.irdata);
    checkOutput("dreaddata", idx, dreaddata, e.drdata);
    checkOutput("timeout", idx, {31'd0, timeout}, 32'd0);
  endtask

  localparam exp_t EXP_IDLE = '{1'b0, 1'b0, 32'd0, 32'd0, 4'h0, 1'b1, 1'b1, 32'd0, 32'd0};

  // Table: each entry is one clock cycle; inputs driven at the falling edge.
  task automatic buildTable();
    // reset held
    vecs.push_back('{'{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0}, EXP_IDLE});
    // lone instruction read, zero-wait slave
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h12345678}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h12345678},
                     '{1'b1, 1'b0, 32'h100, 32'h0, 4'hf, 1'b0, 1'b1, 32'h12345678, 32'h0}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h12345678}, EXP_IDLE});
    // data write with three wait cycles
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h2000, 32'hA5A5A5A5, 4'h3, 1'b1, 32'h0}, EXP_IDLE});
    for (int k = 0; k < 3; k++) begin
      vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h2000, 32'hA5A5A5A5, 4'h3, 1'b1, 32'h0},
                       '{1'b0, 1'b1, 32'h2000, 32'hA5A5A5A5, 4'h3, 1'b1, 1'b1, 32'h0, 32'h0}});
    end
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h2000, 32'hA5A5A5A5, 4'h3, 1'b0, 32'h0},
                     '{1'b0, 1'b1, 32'h2000, 32'hA5A5A5A5, 4'h3, 1'b1, 1'b0, 32'h0, 32'h0}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h2000, 32'hA5A5A5A5, 4'h3, 1'b0, 32'h0}, EXP_IDLE});
    // reset asserted mid-write, then a pending instruction read
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40, 32'h1111, 4'hf, 1'b1, 32'h0}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h40, 32'h1111, 4'hf, 1'b1, 32'h0},
                     '{1'b0, 1'b1, 32'h40, 32'h1111, 4'hf, 1'b1, 1'b1, 32'h0, 32'h0}});
    vecs.push_back('{'{1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h40, 32'h1111, 4'hf, 1'b1, 32'h0}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h40, 32'h1111, 4'hf, 1'b0, 32'h0BADF00D}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h40, 32'h1111, 4'hf, 1'b0, 32'h0BADF00D},
                     '{1'b1, 1'b0, 32'h300, 32'h0, 4'hf, 1'b0, 1'b1, 32'h0BADF00D, 32'h0}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h40, 32'h1111, 4'hf, 1'b0, 32'h0}, EXP_IDLE});
    // write and read together: write first, read on the next grant
    vecs.push_back('{'{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h500, 32'h77, 4'hc, 1'b0, 32'hCAFEF00D}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h500, 32'h77, 4'hc, 1'b0, 32'hCAFEF00D},
                     '{1'b0, 1'b1, 32'h500, 32'h77, 4'hc, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h77, 4'hc, 1'b0, 32'hCAFEF00D}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h500, 32'h77, 4'hc, 1'b0, 32'hCAFEF00D},
                     '{1'b1, 1'b0, 32'h500, 32'h77, 4'hc, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h500, 32'h77, 4'hc, 1'b0, 32'h0}, EXP_IDLE});
    // granted instruction master drops its strobe before completion
    vecs.push_back('{'{1'b1, 1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0}, EXP_IDLE});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0},
                     '{1'b0, 1'b0, 32'h600, 32'h0, 4'hf, 1'b1, 1'b1, 32'h0, 32'h0}});
    vecs.push_back('{'{1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0}, EXP_IDLE});
  endtask

  task automatic doReset();
    @(negedge clk);
    nreset = 1'b0;
    iread = 1'b0; dread = 1'b0; dwrite = 1'b0; swaitrequest = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    nreset = 1'b0;
    iread = 1'b0; dread = 1'b0; dwrite = 1'b0;
    iaddress = 32'h0; daddress = 32'h0; dwritedata = 32'h0; dbyteenable = 4'h0;
    swaitrequest = 1'b0; sreaddata = 32'h0;

    buildTable();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].s);
      #2;
      checkVector(i, vecs[i].e);
    end

    // Both masters requesting continuously from reset release.
    doReset();
    iread = 1'b1; dread = 1'b1; iaddress = 32'h100; daddress = 32'h200;
    swaitrequest = 1'b0; sreaddata = 32'h55AA55AA;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) @(negedge clk);
      #2;
      if (c % 2 == 0) begin
        checkOutput("rr_bubble_sread", c, {31'd0, sread}, 32'd0);
        checkOutput("fp_bubble_sread", c, {31'd0, fp_sread}, 32'd0);
      end else begin
        checkOutput("rr_sread", c, {31'd0, sread}, 32'd1);
        checkOutput("rr_saddress", c, saddress, ((c / 2) % 2 == 0) ? 32'h200 : 32'h100);
        checkOutput("rr_iwait", c, {31'd0, iwaitrequest}, ((c / 2) % 2 == 0) ? 32'd1 : 32'd0);
        checkOutput("rr_dwait", c, {31'd0, dwaitrequest}, ((c / 2) % 2 == 0) ? 32'd0 : 32'd1);
        checkOutput("fp_saddress", c, fp_saddress, 32'h200);
        checkOutput("fp_dwait", c, {31'd0, fp_dwaitrequest}, 32'd0);
        checkOutput("fp_dreaddata", c, fp_dreaddata, 32'h55AA55AA);
      end
      checkOutput("fp_iwait", c, {31'd0, fp_iwaitrequest}, 32'd1);
    end

`ifdef RV_MEM_ARB_TIMEOUT_EN
    // Slave stuck in wait on an instruction read; abort after TIMEOUT_CYCLES.
    doReset();
    iread = 1'b1; iaddress = 32'h700; swaitrequest = 1'b1; sreaddata = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      #2;
      if (c >= 1 && c <= 7) begin
        checkOutput("to_stall_sread", c, {31'd0, sread}, 32'd1);
        checkOutput("to_stall_iwait", c, {31'd0, iwaitrequest}, 32'd1);
        checkOutput("to_stall_timeout", c, {31'd0, timeout}, 32'd0);
      end else if (c == 8) begin
        checkOutput("to_abort_timeout", c, {31'd0, timeout}, 32'd1);
        checkOutput("to_abort_iwait", c, {31'd0, iwaitrequest}, 32'd0);
        checkOutput("to_abort_ireaddata", c, ireaddata, 32'hDEADBEEF);
        checkOutput("to_abort_sread", c, {31'd0, sread}, 32'd0);
      end else if (c == 9) begin
        checkOutput("to_idle_sread", c, {31'd0, sread}, 32'd0);
        checkOutput("to_idle_iwait", c, {31'd0, iwaitrequest}, 32'd1);
        checkOutput("to_idle_timeout", c, {31'd0, timeout}, 32'd0);
      end
    end
    iread = 1'b0;
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one Avalon-style memory slave port between the two master ports of the RISC-V co-simulation wrapper: instruction (i*) and data (d*).
- Sits between the virtual processor wrapper and a unified memory model.
- Used when Harvard mode is enabled in the processor but memory is single-ported.
- Registered grant; one transaction per grant; round-robin or fixed-priority arbitration.

Parameters:
- ARB_MODE, 0, 0 = round-robin between I and D; 1 = fixed priority, data wins.
- TIMEOUT_CYCLES, 1024, slave-stall limit before abort. Used only with the optional feature.
- ABORT_DATA, 32'hDEADBEEF, readdata returned on a timed-out read.

Ports:
- clk  in  1  system clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- iaddress  in  32  instruction master address
- iread  in  1  instruction master read request
- ireaddata  out  32  instruction read data
- iwaitrequest  out  1  instruction master stall
- daddress  in  32  data master address
- dwrite  in  1  data master write request
- dwritedata  in  32  data master write data
- dbyteenable  in  4  data master byte enables
- dread  in  1  data master read request
- dreaddata  out  32  data read data
- dwaitrequest  out  1  data master stall
- saddress  out  32  slave address
- swrite  out  1  slave write strobe
- swritedata  out  32  slave write data
- sbyteenable  out  4  slave byte enables
- sread  out  1  slave read strobe
- sreaddata  in  32  slave read data
- swaitrequest  in  1  slave stall
- timeout  out  1  one-cycle abort pulse; tied 0 without the optional feature

Behaviour:
- Reset: state=IDLE, last_grant=I (so D wins the first tie in round-robin), timeout=0.
- Reset outputs: iwaitrequest=1, dwaitrequest=1, swrite=0, sread=0, saddress/swritedata=0, sbyteenable=0.
- Reset asserted mid-transaction: slave strobes drop immediately (asynchronous); the transaction is abandoned.
- States: IDLE, GNT_I, GNT_D. State and last_grant are registered.
- IDLE, no request (dread|dwrite|iread) sampled at an edge: stay IDLE.
- IDLE with requests: choose the next state.
  - ARB_MODE=1: D if D requests, else I.
  - ARB_MODE=0, both request: grant the one not equal to last_grant.
  - Single requester: it wins.
  - last_grant updates on entry to a GNT state.
- GNT_x: slave command signals are combinational muxes of the granted master's inputs.
  - sbyteenable=4'hf for I; dbyteenable for D.
  - Non-granted master: waitrequest=1, readdata=0.
  - Granted master: waitrequest=swaitrequest, readdata=sreaddata.
- In IDLE, slave strobes are 0 and both waitrequests are 1.
- Completion: a cycle in GNT_x with the master strobe high and swaitrequest=0. Next state is IDLE, giving a one-cycle bubble between transactions.
- Granted master drops its strobe before completion (protocol violation): return to IDLE next cycle; no slave strobe is issued that cycle.
- Data master with dwrite & dread both high: the write is issued, sread=0. The read is serviced on a later grant if still asserted.
- Latency: request at edge N gives a slave strobe in cycle N+1. Minimum 2 cycles per access with a zero-wait slave.
- Masters must hold address/data stable while waitrequest=1. The arbiter does not register them.

Optional Feature:
- Macro RV_MEM_ARB_TIMEOUT_EN.
- When defined: a 16-bit stall counter clears on entry to GNT_x and increments each GNT cycle with swaitrequest=1.
- Counter reaching TIMEOUT_CYCLES-1 triggers an abort on the following cycle:
  - granted master waitrequest=0, readdata=ABORT_DATA;
  - slave strobes forced 0;
  - timeout=1 for one cycle;
  - next state IDLE.
- When undefined: no counter; timeout is tied 0; a stalled slave stalls indefinitely.

Test Plan:
- Only iread, addr 0x100, slave zero-wait returning 0x12345678 -> sread in cycle 1, ireaddata=0x12345678 with iwaitrequest=0 in cycle 1, state IDLE in cycle 2.
- Reset release, ARB_MODE=0, iread and dread held continuously -> grant order D,I,D,I.
  - With ARB_MODE=1 -> D,D,D; I never granted.
- dwrite addr 0x2000, data 0xA5A5A5A5, be=4'h3, slave waits 3 cycles -> swrite high 4 cycles, sbyteenable=4'h3, dwaitrequest low only in the 4th.
- nreset driven low while GNT_D with swaitrequest=1 -> swrite/sread=0 and both waitrequests=1 immediately; after release, a pending iread is granted normally.
- dwrite & dread together -> only swrite asserted; after the write completes, sread issued for the held dread.
- With RV_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave stuck at swaitrequest=1 on an iread:
  - abort: timeout pulse, iwaitrequest=0, ireaddata=0xDEADBEEF;
  - next cycle: IDLE with no slave strobe.
